// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial a - b - borrow_in, LSB first, one full-
//                     subtractor cell plus a borrow flop, start/busy/done.
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_bit_valid,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic             w_a0;
  logic             w_b0;
  logic             w_diff_bit;
  logic             w_next_br;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_a0       = r_a_sr[0];
  assign w_b0       = r_b_sr[0];
  assign w_diff_bit = w_a0 ^ w_b0 ^ r_br;
  assign w_next_br  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  assign w_last     = (r_cnt == C_LAST);
  // Result fills from the MSB end so that after WIDTH shifts bit 0 is the LSB.
  assign w_res_next = {w_diff_bit, r_res[WIDTH-1:1]};

  // busy is registered and high exactly while in SHIFT, so it gates the cell.
  assign diff_bit = busy & w_diff_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_a_sr         <= '0;
      r_b_sr         <= '0;
      r_res          <= '0;
      r_br           <= 1'b0;
      r_cnt          <= '0;
      busy           <= 1'b0;
      diff_bit_valid <= 1'b0;
      done           <= 1'b0;
      diff           <= '0;
      borrow_out     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sr         <= a;
            r_b_sr         <= b;
            r_br           <= borrow_in;
            r_res          <= '0;
            r_cnt          <= '0;
            busy           <= 1'b1;
            diff_bit_valid <= 1'b1;
            r_state        <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_res  <= w_res_next;
          r_br   <= w_next_br;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            diff           <= w_res_next;
            borrow_out     <= w_next_br;
            busy           <= 1'b0;
            diff_bit_valid <= 1'b0;
            done           <= 1'b1;
            r_state        <= ST_DONE;
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          busy           <= 1'b0;
          diff_bit_valid <= 1'b0;
          done           <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : vector table, corner sequences and random ops for
//                        serial_subtractor, checked through a result queue.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             diff_bit;
  logic             diff_bit_valid;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .a              (a),
    .b              (b),
    .borrow_in      (borrow_in),
    .busy           (busy),
    .diff_bit       (diff_bit),
    .diff_bit_valid (diff_bit_valid),
    .done           (done),
    .diff           (diff),
    .borrow_out     (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected {borrow_out, diff} per accepted operation, in order.
  logic [WIDTH:0] sb[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // Monitor: reassembles the serial stream and pops the scoreboard on done.
  int             bit_idx  = 0;
  int             busy_cnt = 0;
  logic [WIDTH-1:0] stream = '0;

  always @(negedge clk) begin
    logic [WIDTH:0] exp;
    if (!rst_n) begin
      bit_idx  = 0;
      busy_cnt = 0;
      stream   = '0;
    end else begin
      if (diff_bit_valid !== busy) chk("valid_vs_busy", 32'(diff_bit_valid), 32'(busy));
      if (!diff_bit_valid && diff_bit !== 1'b0) chk("diff_bit_idle", 32'(diff_bit), 32'd0);
      if (busy) busy_cnt++;
      if (diff_bit_valid) begin
        if (bit_idx < WIDTH) stream[bit_idx] = diff_bit;
        bit_idx++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          fail("unexpected_done");
        end else begin
          exp = sb.pop_front();
          chk("diff", 32'(diff), 32'(exp[WIDTH-1:0]));
          chk("borrow_out", 32'(borrow_out), 32'(exp[WIDTH]));
          chk("serial_stream", 32'(stream), 32'(exp[WIDTH-1:0]));
          chk("busy_cycles", 32'(busy_cnt), WIDTH);
        end
        bit_idx  = 0;
        busy_cnt = 0;
        stream   = '0;
      end
    end
  end

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic bi);
    return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
  endfunction

  // Issue one operation from IDLE and check the start-to-done latency.
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic bi, input logic [WIDTH:0] exp);
    int lat;
    @(negedge clk);
    a = x; b = y; borrow_in = bi; start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); borrow_in = 1'($urandom);
    lat = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done && lat < WIDTH + 6) begin
      @(negedge clk);
      lat++;
    end
    if (!done) fail("done_timeout");
    else chk("latency", lat, WIDTH + 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 3 * WIDTH) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail("done_timeout");
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int gap;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rbi;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(diff_bit_valid), 32'd0);
    chk("rst_diff_bit", 32'(diff_bit), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow_out", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].exp_bout, vecs[i].exp_diff});

    // Start ignored mid-shift, then start held high for back-to-back.
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; borrow_in = 1'b0; start = 1'b1;
    sb.push_back({1'b0, 8'h4B});
    @(negedge clk); start = 1'b0; a = 8'h77; b = 8'h99;
    @(negedge clk);
    @(negedge clk); a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
    sb.push_back({1'b0, 8'h22});
    wait_done(n);
    @(negedge clk);
    gap = 1;
    @(negedge clk);
    gap++;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("diff_hold", 32'(diff), 32'h4B);
    start = 1'b0;
    while (!done && gap < 3 * WIDTH) begin
      @(negedge clk);
      gap++;
    end
    if (!done) fail("b2b_timeout");
    else chk("b2b_gap", gap, WIDTH + 2);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(diff_bit_valid), 32'd0);
    chk("arst_diff_bit", 32'(diff_bit), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_borrow_out", 32'(borrow_out), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 2) @(negedge clk);
    chk("no_done_after_reset", 32'(sb.size()), 32'd0);
    do_op(8'h03, 8'h01, 1'b0, {1'b0, 8'h02});

    for (int i = 0; i < 1000; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rbi = 1'($urandom);
      do_op(ra, rb, rbi, model(ra, rb, rbi));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
